cg_iteration_sequencer: RTL and testbench

Top-level sequencer for the conjugate-gradient solver datapath (ALU plus P/R/X/Rprev memories). One solve request is run as repeated CG iterations. Each iteration steps through these phases in order:
- matrix-vector product
- dot product
- x/r update
- p/Rprev update
- convergence check

The block pulses the ALU sub-unit resets, waits for each phase's finish handshake, and sweeps memory addresses with the matching write enables. Iterations repeat until the ALU flags convergence or the iteration limit is reached.

---
 rtl/cg_iteration_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cg_iteration_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_iteration_sequencer.sv
// Phase sequencer for the CG solver: pulses ALU sub-unit resets, waits on finish handshakes, sweeps memories.
// Optional watchdog on the ALU wait phases enabled by defining CG_TIMEOUT_EN.
module cg_iteration_sequencer #(
  parameter int unsigned number_of_clusters     = 40,
  parameter int unsigned memories_address_width = 20,
  parameter int unsigned max_iterations         = 64,
  parameter int unsigned timeout_cycles         = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_solve,
  input  logic                              mXv1_finish,
  input  logic                              vXv1_finish,
  input  logic                              converged,
  output logic                              reset_mXv1,
  output logic                              reset_vXv1,
  output logic [memories_address_width-1:0] memory_read_address,
  output logic                              memoryRprev_we,
  output logic                              memoryX_we,
  output logic                              memoryR_we,
  output logic                              memoryP_we,
  output logic [2:0]                        phase,
  output logic [15:0]                       iteration_count,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout
);

  localparam int unsigned AW = memories_address_width;
  localparam logic [AW-1:0] last_addr  = AW'(number_of_clusters - 1);
  localparam logic [15:0]   iter_limit = 16'(max_iterations);

  if (max_iterations < 1 || timeout_cycles < 1 || number_of_clusters < 1) begin : g_param_check
    $error("cg_iteration_sequencer: parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    MXV    = 3'd2,
    VXV    = 3'd3,
    UPD_XR = 3'd4,
    UPD_P  = 3'd5,
    CHECK  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic          sweep_last;
  logic          timeout_hit;
  logic [AW-1:0] address_nxt;
  logic          reset_mxv_nxt, reset_vxv_nxt;
  logic [3:0]    we_nxt;
  logic          start_accept;

`ifdef CG_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(timeout_cycles + 1);
  localparam logic [WDW-1:0] wd_last = WDW'(timeout_cycles - 1);
  logic [WDW-1:0] wd_count, wd_nxt;
`endif

  assign phase        = 3'(state);
  assign start_accept = (state == IDLE) && start_solve;

  // Next-state and registered-output precompute
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    sweep_last  = (memory_read_address == last_addr);
    case (state)
      IDLE:   if (start_solve) state_nxt = INIT;
      INIT:   if (sweep_last) state_nxt = MXV;
      MXV: begin
        // reset_mXv1 is high only on the entry cycle, so it masks an early finish
        if (!reset_mXv1 && mXv1_finish) state_nxt = VXV;
`ifdef CG_TIMEOUT_EN
        else if (wd_count == wd_last) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
`endif
      end
      VXV: begin
        if (!reset_vXv1 && vXv1_finish) state_nxt = UPD_XR;
`ifdef CG_TIMEOUT_EN
        else if (wd_count == wd_last) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
`endif
      end
      UPD_XR: if (sweep_last) state_nxt = UPD_P;
      UPD_P:  if (sweep_last) state_nxt = CHECK;
      CHECK:  state_nxt = (converged || (iteration_count + 16'd1 == iter_limit)) ? DONE : MXV;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if ((state == INIT || state == UPD_XR || state == UPD_P) && !sweep_last)
      address_nxt = memory_read_address + AW'(1);
    else
      address_nxt = '0;

    reset_mxv_nxt = (state_nxt == MXV) && (state != MXV);
    reset_vxv_nxt = (state_nxt == VXV) && (state != VXV);

    // {Rprev, X, R, P}
    case (state_nxt)
      INIT:    we_nxt = 4'b1000;
      UPD_XR:  we_nxt = 4'b0110;
      UPD_P:   we_nxt = 4'b1001;
      default: we_nxt = 4'b0000;
    endcase

`ifdef CG_TIMEOUT_EN
    wd_nxt = ((state == MXV || state == VXV) && state_nxt == state) ? wd_count + WDW'(1) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      memory_read_address <= '0;
      reset_mXv1          <= 1'b0;
      reset_vXv1          <= 1'b0;
      memoryRprev_we      <= 1'b0;
      memoryX_we          <= 1'b0;
      memoryR_we          <= 1'b0;
      memoryP_we          <= 1'b0;
      iteration_count     <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state               <= state_nxt;
      memory_read_address <= address_nxt;
      reset_mXv1          <= reset_mxv_nxt;
      reset_vXv1          <= reset_vxv_nxt;
      {memoryRprev_we, memoryX_we, memoryR_we, memoryP_we} <= we_nxt;
      busy                <= (state_nxt != IDLE) && (state_nxt != DONE);
      done                <= (state_nxt == DONE);
      if (start_accept)
        iteration_count <= '0;
      else if (state == CHECK)
        iteration_count <= iteration_count + 16'd1;
    end
  end

`ifdef CG_TIMEOUT_EN
  // Watchdog: timeout stays set until the next accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else begin
      wd_count <= wd_nxt;
      if (start_accept)
        timeout <= 1'b0;
      else if (timeout_hit)
        timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Scoreboard bench for cg_iteration_sequencer: expected sweep beats are queued per solve and
// popped by a monitor; handshake latencies and completion state are checked at done.
`timescale 1ns/1ps
module tb_cg_iteration_sequencer;

  localparam int unsigned NC = 4;
  localparam int unsigned MI = 3;
  localparam int unsigned AW = 20;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_solve = 1'b0;
  logic          converged = 1'b0;
  logic          spur_mxv = 1'b0;
  logic          resp_mxv = 1'b0;
  logic          resp_vxv = 1'b0;
  logic          mXv1_finish, vXv1_finish;
  logic          reset_mXv1, reset_vXv1;
  logic [AW-1:0] memory_read_address;
  logic          memoryRprev_we, memoryX_we, memoryR_we, memoryP_we;
  logic [2:0]    phase;
  logic [15:0]   iteration_count;
  logic          busy, done, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_dly = 2;
  bit resp_en_mxv = 1'b1;
  bit resp_en_vxv = 1'b1;
  logic [31:0] sb_q[$];

  assign mXv1_finish = resp_mxv | spur_mxv;
  assign vXv1_finish = resp_vxv;

  cg_iteration_sequencer #(
    .number_of_clusters(NC),
    .memories_address_width(AW),
    .max_iterations(MI),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_solve(start_solve),
    .mXv1_finish(mXv1_finish),
    .vXv1_finish(vXv1_finish),
    .converged(converged),
    .reset_mXv1(reset_mXv1),
    .reset_vXv1(reset_vXv1),
    .memory_read_address(memory_read_address),
    .memoryRprev_we(memoryRprev_we),
    .memoryX_we(memoryX_we),
    .memoryR_we(memoryR_we),
    .memoryP_we(memoryP_we),
    .phase(phase),
    .iteration_count(iteration_count),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat(input logic [2:0] ph, input int a, input logic [3:0] we);
    return {5'b0, ph, 20'(a), we};
  endfunction

  task automatic push_sweep(input logic [2:0] ph, input logic [3:0] we);
    for (int k = 0; k < int'(NC); k++) sb_q.push_back(beat(ph, k, we));
  endtask

  task automatic push_solve(input int n_iter);
    push_sweep(3'd1, 4'b1000);
    for (int i = 0; i < n_iter; i++) begin
      push_sweep(3'd4, 4'b0110);
      push_sweep(3'd5, 4'b1001);
    end
  endtask

  // Write-enable monitor: every sweep beat must match the next queued expectation
  always @(negedge clk) begin
    if (!reset && (memoryRprev_we | memoryX_we | memoryR_we | memoryP_we)) begin
      if (sb_q.size() == 0)
        check("sb_extra_beat", beat(phase, int'(memory_read_address),
              {memoryRprev_we, memoryX_we, memoryR_we, memoryP_we}), 32'hFFFF_FFFF);
      else
        check("sb_beat", beat(phase, int'(memory_read_address),
              {memoryRprev_we, memoryX_we, memoryR_we, memoryP_we}), sb_q.pop_front());
    end
  end

  // ALU model: finish returned resp_dly cycles after each start pulse
  always begin
    @(negedge clk);
    if (!reset && reset_mXv1 && resp_en_mxv) begin
      repeat (resp_dly) @(posedge clk);
      #1 resp_mxv = 1'b1;
      @(posedge clk);
      #1 resp_mxv = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (!reset && reset_vXv1 && resp_en_vxv) begin
      repeat (resp_dly) @(posedge clk);
      #1 resp_vxv = 1'b1;
      @(posedge clk);
      #1 resp_vxv = 1'b0;
    end
  end

  task automatic start_pulse();
    @(posedge clk);
    #1 start_solve = 1'b1;
    @(posedge clk);
    #1 start_solve = 1'b0;
  endtask

  // Cycles counted from the edge that sampled start_solve (first following cycle = 1)
  task automatic wait_done(input int limit, output int done_at, output int pulse_at);
    done_at  = -1;
    pulse_at = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (reset_mXv1 && pulse_at < 0) pulse_at = i;
      if (done) begin
        done_at = i;
        break;
      end
    end
    if (done_at < 0) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_done_state(input string tag, input int done_at, input int exp_at,
                                  input int exp_iter, input logic exp_to);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_at));
    check({tag, "_iter_count"}, 32'(iteration_count), 32'(exp_iter));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(phase), 32'd0);
    check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int d_at, p_at;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_addr", 32'(memory_read_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_iter", 32'(iteration_count), 32'd0);
    check("rst_we", {28'd0, memoryRprev_we, memoryX_we, memoryR_we, memoryP_we}, 32'd0);

    // Full run to the iteration limit, finishes 2 cycles after each pulse
    resp_dly = 2;
    push_solve(3);
    start_pulse();
    wait_done(200, d_at, p_at);
    check("limit_first_mxv_pulse", 32'(p_at), 32'(NC + 1));
    check_done_state("limit", d_at, int'(NC) + 3 * (2 * int'(NC) + 7) + 1, 3, 1'b0);

    // Early convergence with minimum-latency finishes
    resp_dly  = 1;
    converged = 1'b1;
    push_solve(1);
    start_pulse();
    wait_done(200, d_at, p_at);
    check_done_state("conv", d_at, int'(NC) + (2 * int'(NC) + 5) + 1, 1, 1'b0);
    converged = 1'b0;

    // Stray mXv finish and start requests while busy must not disturb the run
    resp_dly = 2;
    push_solve(3);
    start_pulse();
    fork
      wait_done(200, d_at, p_at);
      begin
        int n = 0;
        while (phase != 3'd3 && n < 100) begin @(negedge clk); n++; end
        spur_mxv    = 1'b1;
        start_solve = 1'b1;
        while (phase != 3'd5 && n < 200) begin @(negedge clk); n++; end
        spur_mxv    = 1'b0;
        start_solve = 1'b0;
      end
    join
    check_done_state("spur", d_at, int'(NC) + 3 * (2 * int'(NC) + 7) + 1, 3, 1'b0);

    // Reset in the middle of the second x/r update sweep
    push_solve(3);
    start_pulse();
    begin
      int n = 0;
      bit hit = 1'b0;
      while (n < 300) begin
        @(negedge clk);
        n++;
        if (phase == 3'd4 && memory_read_address == AW'(2) && iteration_count == 16'd1) begin
          hit = 1'b1;
          break;
        end
      end
      check("midrst_reached", 32'(hit), 32'd1);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    sb_q.delete();
    check("midrst_phase", 32'(phase), 32'd0);
    check("midrst_addr", 32'(memory_read_address), 32'd0);
    check("midrst_we", {28'd0, memoryRprev_we, memoryX_we, memoryR_we, memoryP_we}, 32'd0);
    check("midrst_iter", 32'(iteration_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    push_solve(3);
    start_pulse();
    wait_done(200, d_at, p_at);
    check_done_state("after_rst", d_at, int'(NC) + 3 * (2 * int'(NC) + 7) + 1, 3, 1'b0);

`ifdef CG_TIMEOUT_EN
    // Watchdog: the mXv finish never arrives
    resp_en_mxv = 1'b0;
    push_sweep(3'd1, 4'b1000);
    start_pulse();
    wait_done(200, d_at, p_at);
    check("wd_delay", 32'(d_at - p_at), 32'(TO));
    check_done_state("wd", d_at, int'(NC) + 1 + int'(TO), 0, 1'b1);
    check("wd_timeout_sticky", 32'(timeout), 32'd1);
    resp_en_mxv = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
